// File: rtl/dma_pkg.sv
// Definitions shared by the read-DMA scheduler and the AXI read DMA engine.
package dma_pkg;

    localparam int unsigned DMA_BITS_TRANS   = 18;
    localparam int unsigned DMA_AXI_WIDTH_AD = 32;
    localparam int unsigned DMA_AXI_WIDTH_DA = 32;
    localparam int unsigned DMA_GUARD_CNT_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BUSY  = 3'd2,
        ST_ZERO  = 3'd3,
        ST_GUARD = 3'd4
    } dma_state_e;

endpackage

// File: rtl/dma_rd_sched_if.sv
// Command/return channel between the read scheduler (master) and the AXI read DMA engine (slave).
interface dma_rd_sched_if #(
    parameter int unsigned BITS_TRANS   = dma_pkg::DMA_BITS_TRANS,
    parameter int unsigned AXI_WIDTH_AD = dma_pkg::DMA_AXI_WIDTH_AD,
    parameter int unsigned AXI_WIDTH_DA = dma_pkg::DMA_AXI_WIDTH_DA
) ();

    logic                    dma_start;
    logic [BITS_TRANS-1:0]   dma_num_trans;
    logic [AXI_WIDTH_AD-1:0] dma_start_addr;
    logic [AXI_WIDTH_DA-1:0] dma_data;
    logic                    dma_data_vld;
    logic [BITS_TRANS-1:0]   dma_data_cnt;
    logic                    dma_done;

    modport master (
        output dma_start, dma_num_trans, dma_start_addr,
        input  dma_data, dma_data_vld, dma_data_cnt, dma_done
    );

    modport slave (
        input  dma_start, dma_num_trans, dma_start_addr,
        output dma_data, dma_data_vld, dma_data_cnt, dma_done
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or above ptr_i, wrapping.
module rr_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0]         valid_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 any_o
);

    localparam int unsigned IW = $clog2(N);

    always_comb begin
        int          j;
        logic [IW-1:0] jj;
        logic        found;
        logic [N-1:0]  gnt;
        logic [IW-1:0] idx;
        j     = 0;
        jj    = '0;
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int k = 0; k < int'(N); k++) begin
            j = int'(ptr_i) + k;
            if (j >= int'(N)) begin
                j = j - int'(N);
            end
            jj = IW'(j);
            if (!found && valid_i[jj]) begin
                found   = 1'b1;
                gnt[jj] = 1'b1;
                idx     = jj;
            end
        end
        gnt_o = gnt;
        idx_o = idx;
        any_o = found;
    end

endmodule

// File: rtl/dma_rd_sched.sv
// Round-robin scheduler sharing one AXI read DMA engine among NUM_REQ loaders.
module dma_rd_sched #(
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned BITS_TRANS   = dma_pkg::DMA_BITS_TRANS,
    parameter int unsigned AXI_WIDTH_AD = dma_pkg::DMA_AXI_WIDTH_AD,
    parameter int unsigned AXI_WIDTH_DA = dma_pkg::DMA_AXI_WIDTH_DA,
    parameter int unsigned GUARD_CYC    = 4
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    input  logic [NUM_REQ*AXI_WIDTH_AD-1:0] req_addr_i,
    input  logic [NUM_REQ*BITS_TRANS-1:0]   req_num_i,
    output logic [AXI_WIDTH_DA-1:0]         rd_data_o,
    output logic [NUM_REQ-1:0]              rd_vld_o,
    output logic [BITS_TRANS-1:0]           rd_cnt_o,
    output logic [NUM_REQ-1:0]              rd_done_o,
    output logic                            busy_o,
    dma_rd_sched_if.master                  dma
);

    import dma_pkg::*;

    localparam int unsigned IDX_W  = $clog2(NUM_REQ);
    localparam int unsigned GCNT_W = DMA_GUARD_CNT_W;

    dma_state_e              state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [IDX_W-1:0]        gidx_q, gidx_d;
    logic [AXI_WIDTH_AD-1:0] addr_q, addr_d;
    logic [BITS_TRANS-1:0]   num_q, num_d;
    logic [GCNT_W-1:0]       gcnt_q, gcnt_d;
    logic                    start_q, start_d;
    logic                    busy_q, busy_d;
    logic                    zdone_q, zdone_d;

    logic [NUM_REQ-1:0]      arb_gnt;
    logic [IDX_W-1:0]        arb_idx;
    logic                    arb_any;
    logic [AXI_WIDTH_AD-1:0] sel_addr;
    logic [BITS_TRANS-1:0]   sel_num;
    logic                    in_busy;
    logic [NUM_REQ-1:0]      gnt_oh;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .valid_i (req_valid_i),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    assign sel_addr = req_addr_i[int'(arb_idx)*AXI_WIDTH_AD +: AXI_WIDTH_AD];
    assign sel_num  = req_num_i[int'(arb_idx)*BITS_TRANS +: BITS_TRANS];

    // Next-state and descriptor capture
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        addr_d  = addr_q;
        num_d   = num_q;
        gcnt_d  = gcnt_q;
        start_d = 1'b0;
        zdone_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    gidx_d = arb_idx;
                    addr_d = sel_addr & ~AXI_WIDTH_AD'(3);
                    num_d  = sel_num;
                    ptr_d  = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
                    if (sel_num == '0) begin
                        state_d = ST_ZERO;
                        zdone_d = 1'b1;
                    end else begin
                        state_d = ST_START;
                        start_d = 1'b1;
                    end
                end
            end
            ST_START: state_d = ST_BUSY;
            ST_BUSY: begin
                if (dma.dma_done) begin
                    state_d = ST_GUARD;
                    gcnt_d  = GCNT_W'(GUARD_CYC - 1);
                end
            end
            ST_ZERO: state_d = ST_IDLE;
            ST_GUARD: begin
                if (gcnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gcnt_d = gcnt_q - GCNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            addr_q  <= '0;
            num_q   <= '0;
            gcnt_q  <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            zdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            addr_q  <= addr_d;
            num_q   <= num_d;
            gcnt_q  <= gcnt_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            zdone_q <= zdone_d;
        end
    end

    // Return path is a zero-latency pass-through, steered to the granted requester in BUSY only
    assign in_busy     = (state_q == ST_BUSY);
    assign gnt_oh      = NUM_REQ'(1) << gidx_q;
    assign req_ready_o = (state_q == ST_IDLE) ? arb_gnt : '0;
    assign rd_vld_o    = (in_busy && dma.dma_data_vld) ? gnt_oh : '0;
    assign rd_done_o   = ((in_busy && dma.dma_done) || zdone_q) ? gnt_oh : '0;
    assign rd_data_o   = in_busy ? dma.dma_data : '0;
    assign rd_cnt_o    = in_busy ? dma.dma_data_cnt : '0;
    assign busy_o      = busy_q;

    assign dma.dma_start      = start_q;
    assign dma.dma_num_trans  = num_q;
    assign dma.dma_start_addr = addr_q;

endmodule

// File: tb/tb_dma_rd_sched.sv
// Self-checking bench for dma_rd_sched: descriptor table, DMA model and return-beat scoreboard.
module tb_dma_rd_sched;

    localparam int unsigned NR = 3;
    localparam int unsigned BT = 18;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned GC = 4;

    logic            clk = 1'b0;
    logic            rstn;
    logic [NR-1:0]   req_valid_i;
    logic [NR-1:0]   req_ready_o;
    logic [NR*AW-1:0] req_addr_i;
    logic [NR*BT-1:0] req_num_i;
    logic [DW-1:0]   rd_data_o;
    logic [NR-1:0]   rd_vld_o;
    logic [BT-1:0]   rd_cnt_o;
    logic [NR-1:0]   rd_done_o;
    logic            busy_o;

    dma_rd_sched_if #(.BITS_TRANS(BT), .AXI_WIDTH_AD(AW), .AXI_WIDTH_DA(DW)) dma_if ();

    dma_rd_sched #(
        .NUM_REQ(NR), .BITS_TRANS(BT), .AXI_WIDTH_AD(AW), .AXI_WIDTH_DA(DW), .GUARD_CYC(GC)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_num_i   (req_num_i),
        .rd_data_o   (rd_data_o),
        .rd_vld_o    (rd_vld_o),
        .rd_cnt_o    (rd_cnt_o),
        .rd_done_o   (rd_done_o),
        .busy_o      (busy_o),
        .dma         (dma_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NR-1:0] mask;
        logic [BT-1:0] num;
        logic [AW-1:0] addr;
        logic [NR-1:0] exp;
    } vec_t;

    typedef struct {
        logic [NR-1:0] oh;
        logic [DW-1:0] data;
        logic [BT-1:0] cnt;
    } beat_t;

    vec_t  vecs[9];
    beat_t sb[$];
    int    vld_cnt[NR];
    int    errs   = 0;
    int    checks = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard consumer: every returned beat must match the oldest driven beat
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (rd_vld_o != '0) begin
                for (int i = 0; i < int'(NR); i++) if (rd_vld_o[i]) vld_cnt[i]++;
                if (sb.size() == 0) begin
                    check("unexpected_vld", 128'(rd_vld_o), 128'(0));
                end else begin
                    e = sb.pop_front();
                    check("beat", 128'({rd_vld_o, rd_data_o, rd_cnt_o}), 128'({e.oh, e.data, e.cnt}));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    task automatic run_entry(input logic [NR-1:0] mask, input logic [BT-1:0] num, input logic [AW-1:0] addr,
                             input logic [NR-1:0] exp, input int abort_at, input bit wd);
        int          eidx;
        int          b;
        int          k;
        int          base[NR];
        bit          first;
        logic [DW-1:0] d;
        logic [95:0] act_c;
        logic [95:0] exp_c;
        eidx = 0;
        for (int i = 0; i < int'(NR); i++) if (exp[i]) eidx = i;
        for (int i = 0; i < int'(NR); i++) begin
            base[i] = vld_cnt[i];
            req_addr_i[i*AW +: AW] = addr + 32'(i - eidx) * 32'h0001_0000;
            req_num_i[i*BT +: BT]  = (i == eidx) ? num : num + 18'(i + 1);
        end
        req_valid_i = mask;
        k = 0;
        #1;
        while (req_ready_o == '0 && k < 40) begin
            @(posedge clk); #2;
            k++;
        end
        check("grant", 128'(req_ready_o), 128'(exp));
        check("idle_busy", 128'(busy_o), 128'(0));
        @(posedge clk); #1;
        req_valid_i = '0;
        @(negedge clk);
        if (num == '0) begin
            check("zero_done", 128'({rd_done_o, dma_if.dma_start, busy_o}), 128'({exp, 1'b0, 1'b1}));
            @(negedge clk);
            check("zero_after", 128'({rd_done_o, dma_if.dma_start, busy_o}), 128'(0));
            return;
        end
        check("start", 128'({dma_if.dma_start, dma_if.dma_start_addr, dma_if.dma_num_trans}),
              128'({1'b1, addr & 32'hFFFF_FFFC, num}));
        b = 0;
        first = 1'b1;
        while (b < int'(num)) begin
            @(posedge clk); #1;
            if (wd) req_valid_i = 3'b001;
            if (b == abort_at) begin
                rstn = 1'b0;
                dma_if.dma_data_vld = 1'b1;
                #1;
                check("reset_outputs", 128'({busy_o, dma_if.dma_start, dma_if.dma_num_trans, dma_if.dma_start_addr,
                      rd_vld_o, rd_done_o, rd_data_o, rd_cnt_o, req_ready_o}), 128'(0));
                @(posedge clk); #1;
                dma_if.dma_data_vld = 1'b0;
                rstn = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    check("reset_no_done", 128'({rd_done_o, busy_o, dma_if.dma_start}), 128'(0));
                end
                return;
            end
            if ($urandom_range(0, 3) == 0) begin
                dma_if.dma_data_vld = 1'b0;
            end else begin
                d = $urandom;
                dma_if.dma_data     = d;
                dma_if.dma_data_cnt = 18'(b);
                dma_if.dma_data_vld = 1'b1;
                sb.push_back('{exp, d, 18'(b)});
                b++;
            end
            if (first) begin
                @(negedge clk);
                check("start_1cyc", 128'(dma_if.dma_start), 128'(0));
                first = 1'b0;
            end
        end
        @(posedge clk); #1;
        dma_if.dma_data_vld = 1'b0;
        dma_if.dma_done     = 1'b1;
        @(negedge clk);
        check("done", 128'(rd_done_o), 128'(exp));
        // Guard window: stray DMA strobes must be ignored and no new start may appear
        for (int g = 0; g < int'(GC); g++) begin
            @(posedge clk); #1;
            dma_if.dma_done     = (g % 2 == 0);
            dma_if.dma_data_vld = 1'b1;
            if (wd) req_valid_i = (g < 2) ? 3'b001 : 3'b000;
            @(negedge clk);
            check("guard", 128'({busy_o, dma_if.dma_start, rd_done_o, req_ready_o}), 128'({1'b1, 1'b0, 3'b0, 3'b0}));
        end
        @(posedge clk); #1;
        dma_if.dma_done     = 1'b0;
        dma_if.dma_data_vld = 1'b0;
        @(negedge clk);
        check("idle_after_guard", 128'({busy_o, req_ready_o, dma_if.dma_start}), 128'(0));
        check("sb_empty", 128'(sb.size()), 128'(0));
        for (int i = 0; i < int'(NR); i++) begin
            act_c[i*32 +: 32] = 32'(vld_cnt[i] - base[i]);
            exp_c[i*32 +: 32] = (i == eidx) ? 32'(num) : 32'd0;
        end
        check("vld_count", 128'(act_c), 128'(exp_c));
        @(posedge clk); #1;
        dma_if.dma_done     = 1'b1;
        dma_if.dma_data_vld = 1'b1;
        @(negedge clk);
        check("idle_stray", 128'({busy_o, rd_done_o, rd_vld_o, dma_if.dma_start}), 128'(0));
        @(posedge clk); #1;
        dma_if.dma_done     = 1'b0;
        dma_if.dma_data_vld = 1'b0;
        @(negedge clk);
        check("idle_hold", 128'({busy_o, dma_if.dma_start, req_ready_o}), 128'(0));
    endtask

    initial begin
        rstn                = 1'b0;
        req_valid_i         = '0;
        req_addr_i          = '0;
        req_num_i           = '0;
        dma_if.dma_data     = '0;
        dma_if.dma_data_vld = 1'b0;
        dma_if.dma_data_cnt = '0;
        dma_if.dma_done     = 1'b0;

        vecs[0] = '{3'b111, 18'd3,   32'h2000_0001, 3'b001};
        vecs[1] = '{3'b111, 18'd5,   32'h2000_0102, 3'b010};
        vecs[2] = '{3'b111, 18'd2,   32'h2000_0203, 3'b100};
        vecs[3] = '{3'b111, 18'd4,   32'h2000_0300, 3'b001};
        vecs[4] = '{3'b010, 18'd300, 32'h1000_0003, 3'b010};
        vecs[5] = '{3'b100, 18'd0,   32'h3000_0000, 3'b100};
        vecs[6] = '{3'b101, 18'd7,   32'h3000_0105, 3'b001};
        vecs[7] = '{3'b101, 18'd2,   32'h3000_0207, 3'b100};
        vecs[8] = '{3'b011, 18'd0,   32'h3000_0300, 3'b001};

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 128'({busy_o, dma_if.dma_start, dma_if.dma_num_trans, dma_if.dma_start_addr,
              rd_vld_o, rd_done_o, rd_data_o, rd_cnt_o, req_ready_o}), 128'(0));
        rstn = 1'b1;
        @(negedge clk);
        check("post_reset_idle", 128'({busy_o, dma_if.dma_start, req_ready_o}), 128'(0));

        for (int v = 0; v < 9; v++) begin
            run_entry(vecs[v].mask, vecs[v].num, vecs[v].addr, vecs[v].exp, -1, 1'b0);
        end

        // Requester 0 raised during BUSY and withdrawn inside the guard window
        run_entry(3'b010, 18'd5, 32'h4000_0011, 3'b010, -1, 1'b1);
        // Reset at beat 100 of 256, then the pointer must be back at requester 0
        run_entry(3'b010, 18'd256, 32'h5000_0002, 3'b010, 100, 1'b0);
        sb.delete();
        run_entry(3'b101, 18'd3, 32'h6000_0001, 3'b001, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
